// File: rtl/edge_det_pkg.sv
// Shared definitions for the edge detection unit.
// Filter state encoding, default parameters and legal parameter bounds.
package edge_det_pkg;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } filt_st_e;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_CYCLES = 4;
   localparam int DEF_CNT_W       = 8;

   localparam int SYNC_MIN  = 2;
   localparam int SYNC_MAX  = 4;
   localparam int FILT_MIN  = 1;
   localparam int FILT_MAX  = 255;
   localparam int CNT_W_MIN = 1;
   localparam int CNT_W_MAX = 32;

   // Wide enough for the largest legal qualification window.
   localparam int FCNT_W = 8;

   function automatic bit in_range(int v, int lo, int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/edge_sync_filter.sv
// Input synchroniser plus glitch filter.
// A new level is accepted once it has been seen for FILT_CYCLES cycles.
module edge_sync_filter
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Din,
   output logic Din_filt
);

   localparam logic [FCNT_W-1:0] LAST = FCNT_W'(FILT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   filt_st_e               st_q;
   logic [FCNT_W-1:0]      cnt_q;

   if (!in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX)) begin : g_bad_sync
      $error("edge_sync_filter: SYNC_STAGES out of range");
   end
   if (!in_range(FILT_CYCLES, FILT_MIN, FILT_MAX)) begin : g_bad_filt
      $error("edge_sync_filter: FILT_CYCLES out of range");
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Din};
      end
   end

   // cnt_q holds how many consecutive mismatching samples have been seen.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         st_q     <= ST_STABLE;
         cnt_q    <= '0;
         Din_filt <= 1'b0;
      end else begin
         unique case (st_q)
            ST_STABLE: begin
               cnt_q <= '0;
               if (sync_out != Din_filt) begin
                  if (LAST == '0) begin
                     Din_filt <= sync_out;
                  end else begin
                     st_q  <= ST_QUALIFY;
                     cnt_q <= FCNT_W'(1);
                  end
               end
            end
            ST_QUALIFY: begin
               if (sync_out == Din_filt) begin
                  st_q  <= ST_STABLE;
                  cnt_q <= '0;
               end else if (cnt_q == LAST) begin
                  st_q     <= ST_STABLE;
                  cnt_q    <= '0;
                  Din_filt <= sync_out;
               end else begin
                  cnt_q <= cnt_q + FCNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/edge_detect_unit.sv
// Clock-domain-safe edge detector: filtered level, edge pulses,
// saturating per-direction counters and sticky flags.
module edge_detect_unit
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_CYCLES = DEF_FILT_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Din,
   input  logic             Clr,
   output logic             Din_filt,
   output logic             Pos_pulse,
   output logic             Neg_pulse,
   output logic             Any_pulse,
   output logic [CNT_W-1:0] Pos_cnt,
   output logic [CNT_W-1:0] Neg_cnt,
   output logic             Pos_seen,
   output logic             Neg_seen
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic filt_d;

   if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt
      $error("edge_detect_unit: CNT_W out of range");
   end

   edge_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
   ) u_filt (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Din     (Din),
      .Din_filt(Din_filt)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         filt_d    <= 1'b0;
         Pos_pulse <= 1'b0;
         Neg_pulse <= 1'b0;
         Any_pulse <= 1'b0;
      end else begin
         filt_d    <= Din_filt;
         Pos_pulse <= Din_filt & ~filt_d;
         Neg_pulse <= ~Din_filt & filt_d;
         Any_pulse <= Din_filt ^ filt_d;
      end
   end

   // A pulse coinciding with Clr survives as a count of one.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Pos_cnt  <= '0;
         Neg_cnt  <= '0;
         Pos_seen <= 1'b0;
         Neg_seen <= 1'b0;
      end else if (Clr) begin
         Pos_cnt  <= CNT_W'(Pos_pulse);
         Neg_cnt  <= CNT_W'(Neg_pulse);
         Pos_seen <= Pos_pulse;
         Neg_seen <= Neg_pulse;
      end else begin
         if (Pos_pulse && Pos_cnt != CNT_MAX) begin
            Pos_cnt <= Pos_cnt + CNT_W'(1);
         end
         if (Neg_pulse && Neg_cnt != CNT_MAX) begin
            Neg_cnt <= Neg_cnt + CNT_W'(1);
         end
         Pos_seen <= Pos_seen | Pos_pulse;
         Neg_seen <= Neg_seen | Neg_pulse;
      end
   end

endmodule
